// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB LED driver channels.
package rgb_pkg;

  localparam int PWM_W = 16;

  typedef logic [PWM_W-1:0] pwm_val_t;

endpackage

// File: rtl/rgb_pwm_channel_if.sv
// Setting/output bundle for one RGB PWM channel: the controller drives the settings, the channel drives the outputs.
interface rgb_pwm_channel_if
  import rgb_pkg::*;
#(
  parameter int WIDTH = PWM_W
);

  logic [WIDTH-1:0] countmax;
  logic [WIDTH-1:0] hivalue;
  logic             outpulse;
  logic             nopulse;

  modport master (
    output countmax,
    output hivalue,
    input  outpulse,
    input  nopulse
  );

  modport slave (
    input  countmax,
    input  hivalue,
    output outpulse,
    output nopulse
  );

endinterface

// File: rtl/pwm_period_counter.sv
// Period counter with double-buffered period/high-time shadows.
// The shadows reload only at a period boundary, so mid-period setting changes cannot glitch the output.
module pwm_period_counter
  import rgb_pkg::*;
#(
  parameter int WIDTH = PWM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_countmax,
  input  logic [WIDTH-1:0] i_hivalue,
  output logic [WIDTH-1:0] o_cnt,
  output logic [WIDTH-1:0] o_per_q,
  output logic [WIDTH-1:0] o_hi_q
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_per_q;
  logic [WIDTH-1:0] r_hi_q;
  logic             w_boundary;

  // A zero period counts as a boundary on every cycle so new settings are picked up at once.
  always_comb begin
    w_boundary = 1'b0;
    if (r_per_q == {WIDTH{1'b0}}) begin
      w_boundary = 1'b1;
    end else if (r_cnt == (r_per_q - WIDTH'(1))) begin
      w_boundary = 1'b1;
    end else begin
      w_boundary = 1'b0;
    end
  end

  // Counter advance and shadow load at the period boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= {WIDTH{1'b0}};
      r_per_q <= {WIDTH{1'b0}};
      r_hi_q  <= {WIDTH{1'b0}};
    end else if (w_boundary) begin
      r_cnt   <= {WIDTH{1'b0}};
      r_per_q <= i_countmax;
      r_hi_q  <= i_hivalue;
    end else begin
      r_cnt   <= r_cnt + WIDTH'(1);
    end
  end

  assign o_cnt   = r_cnt;
  assign o_per_q = r_per_q;
  assign o_hi_q  = r_hi_q;

endmodule

// File: rtl/rgb_pwm_channel.sv
// Single-colour PWM channel: period counter plus a registered compare stage
// producing the PWM output and a flag for settings that yield a constant level.
module rgb_pwm_channel
  import rgb_pkg::*;
#(
  parameter int WIDTH = PWM_W
) (
  input  logic          clk,
  input  logic          reset,
  rgb_pwm_channel_if.slave bus
);

  logic [WIDTH-1:0] w_cnt;
  logic [WIDTH-1:0] w_per_q;
  logic [WIDTH-1:0] w_hi_q;
  logic             w_pulse_next;
  logic             w_nopulse_next;
  logic             r_outpulse;
  logic             r_nopulse;

  pwm_period_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .i_countmax (bus.countmax),
    .i_hivalue  (bus.hivalue),
    .o_cnt      (w_cnt),
    .o_per_q    (w_per_q),
    .o_hi_q     (w_hi_q)
  );

  // High time >= period saturates to a constant high, which also counts as "no pulse".
  always_comb begin
    w_pulse_next   = 1'b0;
    w_nopulse_next = 1'b1;
    if (w_per_q == {WIDTH{1'b0}}) begin
      w_pulse_next   = 1'b0;
      w_nopulse_next = 1'b1;
    end else begin
      w_pulse_next   = (w_cnt < w_hi_q);
      w_nopulse_next = (w_hi_q == {WIDTH{1'b0}}) || (w_hi_q >= w_per_q);
    end
  end

  // Output registers; reset holds the output low and flags no pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_outpulse <= 1'b0;
      r_nopulse  <= 1'b1;
    end else begin
      r_outpulse <= w_pulse_next;
      r_nopulse  <= w_nopulse_next;
    end
  end

  assign bus.outpulse = r_outpulse;
  assign bus.nopulse  = r_nopulse;

endmodule

// File: tb/tb_rgb_pwm_channel.sv
// Directed bench for rgb_pwm_channel: duty/period patterns, shadow timing, corner settings and async reset.
module tb_rgb_pwm_channel;
  import rgb_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  rgb_pwm_channel_if #(.WIDTH(PWM_W)) bus ();

  rgb_pwm_channel #(
    .WIDTH (PWM_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Hold reset for two edges, then release just after an edge; the next edge is edge 1.
  task automatic do_reset(input logic [15:0] cm, input logic [15:0] hv);
    reset        = 1'b0;
    bus.countmax = cm;
    bus.hivalue  = hv;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b0;
    bus.countmax = 16'd8;
    bus.hivalue  = 16'd6;
    #1;
    tick();
    chk("reset_out", bus.outpulse, 1'b0);
    chk("reset_nop", bus.nopulse, 1'b1);

    // 1: period 8, high 6
    do_reset(16'd8, 16'd6);
    tick();
    chk("t1_edge1_out", bus.outpulse, 1'b0);
    chk("t1_edge1_nop", bus.nopulse, 1'b1);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("t1_out_%0d", i), bus.outpulse, ((i % 8) < 6) ? 1'b1 : 1'b0);
      chk($sformatf("t1_nop_%0d", i), bus.nopulse, 1'b0);
    end

    // 2: alternate high time on each rise; takes effect one period later
    begin
      int hi_exp [3] = '{6, 3, 6};
      for (int j = 0; j < 24; j++) begin
        tick();
        chk($sformatf("t2_out_%0d", j), bus.outpulse, ((j % 8) < hi_exp[j / 8]) ? 1'b1 : 1'b0);
        chk($sformatf("t2_nop_%0d", j), bus.nopulse, 1'b0);
        if ((j % 8) == 0) begin
          bus.hivalue = (bus.hivalue == 16'd6) ? 16'd3 : 16'd6;
        end
      end
    end

    // 3a: zero high time
    do_reset(16'd8, 16'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("t3a_out_%0d", i), bus.outpulse, 1'b0);
      chk($sformatf("t3a_nop_%0d", i), bus.nopulse, 1'b1);
    end

    // 3b/3c: high time equal to / beyond the period saturates high
    for (int v = 8; v <= 9; v++) begin
      do_reset(16'd8, 16'(v));
      tick();
      chk($sformatf("t3_hv%0d_edge1_out", v), bus.outpulse, 1'b0);
      for (int i = 0; i < 12; i++) begin
        tick();
        chk($sformatf("t3_hv%0d_out_%0d", v, i), bus.outpulse, 1'b1);
        chk($sformatf("t3_hv%0d_nop_%0d", v, i), bus.nopulse, 1'b1);
      end
    end

    // 4: disabled, then period 4 / high 1 without reset
    do_reset(16'd0, 16'd5);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("t4_off_out_%0d", i), bus.outpulse, 1'b0);
      chk($sformatf("t4_off_nop_%0d", i), bus.nopulse, 1'b1);
    end
    bus.countmax = 16'd4;
    bus.hivalue  = 16'd1;
    tick();
    chk("t4_load_out", bus.outpulse, 1'b0);
    chk("t4_load_nop", bus.nopulse, 1'b1);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("t4_out_%0d", i), bus.outpulse, ((i % 4) < 1) ? 1'b1 : 1'b0);
      chk($sformatf("t4_nop_%0d", i), bus.nopulse, 1'b0);
    end

    // 5: async reset in the high phase
    do_reset(16'd8, 16'd6);
    for (int i = 0; i < 4; i++) tick();
    chk("t5_pre_out", bus.outpulse, 1'b1);
    chk("t5_pre_nop", bus.nopulse, 1'b0);
    reset = 1'b0;
    #1;
    chk("t5_async_out", bus.outpulse, 1'b0);
    chk("t5_async_nop", bus.nopulse, 1'b1);
    tick();
    chk("t5_held_out", bus.outpulse, 1'b0);
    chk("t5_held_nop", bus.nopulse, 1'b1);
    reset = 1'b1;
    tick();
    chk("t5_rel1_out", bus.outpulse, 1'b0);
    tick();
    chk("t5_rel2_out", bus.outpulse, 1'b1);
    chk("t5_rel2_nop", bus.nopulse, 1'b0);

    // 6: period change 8 -> 5 mid-period
    do_reset(16'd8, 16'd4);
    tick();
    for (int i = 0; i < 18; i++) begin
      logic exp_v;
      tick();
      if (i < 8) exp_v = (i < 4) ? 1'b1 : 1'b0;
      else       exp_v = (((i - 8) % 5) < 4) ? 1'b1 : 1'b0;
      chk($sformatf("t6_out_%0d", i), bus.outpulse, exp_v);
      chk($sformatf("t6_nop_%0d", i), bus.nopulse, 1'b0);
      if (i == 2) bus.countmax = 16'd5;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
